cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_FU functional units.
- Each FU result is captured in a small per-FU FIFO. One result per cycle is granted round-robin and broadcast on registered CDB outputs.
- Those outputs feed the reservation stations' CDB inputs and the ROB.
- Sits between the FU result ports and every CDB consumer. FUs see back-pressure through a per-FU ready signal.

Parameters:
- NUM_FU, 4, number of requesting functional units (2..8).
- DATA_W, 32, result value width.
- ROB_IX_W, 3, ROB index width (ROB size 8).
- FIFO_DEPTH, 2, entries per FU result FIFO (power of two, >=2).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  synchronous active-low reset.
- flush_in  input  1  pipeline flush (mispredict); drops all buffered results.
- fu_valid_in  input  NUM_FU  per-FU result valid.
- fu_rob_ix_in  input  NUM_FU*ROB_IX_W  packed ROB index per FU; FU k occupies bits [k*ROB_IX_W +: ROB_IX_W].
- fu_value_in  input  NUM_FU*DATA_W  packed result value per FU; FU k occupies bits [k*DATA_W +: DATA_W].
- fu_ready_out  output  NUM_FU  per-FU FIFO can accept a result this cycle.
- cdb_valid_out  output  1  CDB broadcast valid.
- cdb_rob_ix_out  output  ROB_IX_W  ROB index being broadcast.
- cdb_value_out  output  DATA_W  value being broadcast.
- cdb_grant_fu_out  output  $clog2(NUM_FU)  index of the FU whose result is on the CDB.

Behaviour:
- Reset (rst_n_in==0 at posedge):
  - All FIFOs empty; rr_ptr=0.
  - cdb_valid_out=0, cdb_rob_ix_out=0, cdb_value_out=0, cdb_grant_fu_out=0.
  - fu_ready_out reads all-ones in the first cycle after reset.
  - Reset applied mid-operation discards all buffered and in-flight results identically.
- fu_ready_out[k]:
  - Combinational, equals (count[k] != FIFO_DEPTH).
  - Depends only on FIFO state, never on same-cycle pop. No pop-through when full.
- Push: fu_valid_in[k] && fu_ready_out[k] at posedge writes {rob_ix, value} to FIFO k. fu_valid_in[k] with ready low is ignored; the FU must hold and retry.
- Arbitration, each cycle:
  - Candidates are FIFOs whose count was nonzero at cycle start. A result pushed this cycle is not eligible until next cycle.
  - Search starts at rr_ptr and ascends with wrap; the first nonempty FIFO g is granted.
  - FIFO g is popped at posedge. Its head is registered onto cdb_*_out, with cdb_valid_out=1 and cdb_grant_fu_out=g.
  - rr_ptr <= (g+1) mod NUM_FU on grant; unchanged with no grant.
  - No candidate: cdb_valid_out<=0. The rob_ix and value outputs hold their previous values.
- Latency: result accepted at posedge ending cycle N appears on the CDB in cycle N+2 when uncontended.
- Throughput: one CDB broadcast per cycle. The CDB has no back-pressure.
- Simultaneous push and pop on the same FIFO: count unchanged, order preserved (FIFO, oldest first).
- Pointer and count rules:
  - FIFO read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - count is $clog2(FIFO_DEPTH)+1 bits.
- Flush (flush_in==1 at posedge, rst_n_in==1):
  - All FIFOs emptied; same-cycle pushes dropped; no grant; rr_ptr<=0.
  - cdb_valid_out<=0 the next cycle.
  - Flush has priority over push and pop. Reset has priority over flush.
- Ordering guarantee: results from the same FU broadcast in acceptance order. No ordering between different FUs.

Optional Feature:
- Macro: CDB_ARBITER_STATS_EN.
- Defined:
  - Adds output conflict_count_out, 16 bits.
  - Increments by 1 on each posedge where two or more FIFOs were nonempty at cycle start.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then single push: FU1 pushes rob_ix=3, value=32'h0000_00AA in cycle 1 -> cycle 3 cdb_valid_out=1, cdb_rob_ix_out=3, cdb_value_out=32'hAA, cdb_grant_fu_out=1; cycle 4 cdb_valid_out=0.
- Round-robin fairness: FU0..FU3 push rob_ix 0..3 in the same cycle, rr_ptr=0 -> CDB shows rob_ix 0,1,2,3 on four consecutive cycles. Repeat with rr_ptr left at 2 -> order 2,3,0,1.
- Back-pressure and order: FU2 pushes values 10, 11, then holds 12 while the CDB is busy with FU0/FU1 traffic (FIFO_DEPTH=2).
  - fu_ready_out[2]=0 once the FIFO is full; the held value 12 is not accepted.
  - 12 is accepted the cycle after a pop of FU2's FIFO.
  - Broadcast order for FU2 is 10, 11, 12.
- Flush: fill FIFOs 0 and 3 with 2 entries each, assert flush_in one cycle with FU1 valid -> cdb_valid_out=0 the next cycle, all fu_ready_out=1, FU1 result never broadcast, subsequent grant order restarts at FU0.
- Reset mid-stream: assert rst_n_in=0 while the CDB is streaming -> all CDB outputs 0 next cycle, no stale results after release.
- Stats (CDB_ARBITER_STATS_EN): FU0 and FU1 each push one result in the same cycle -> conflict_count_out=1 after the grant cycle. Force more than 65535 contended cycles -> holds at 16'hFFFF.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs with round-robin grant onto a registered common data bus.
// Optional CDB_ARBITER_STATS_EN adds a saturating 16-bit count of contended cycles.
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int DATA_W = 32,
    parameter int ROB_IX_W = 3,
    parameter int FIFO_DEPTH = 2,
    localparam int GW = $clog2(NUM_FU),
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1,
    localparam int EW = ROB_IX_W + DATA_W
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         flush_in,
    input  logic [NUM_FU-1:0]            fu_valid_in,
    input  logic [NUM_FU*ROB_IX_W-1:0]   fu_rob_ix_in,
    input  logic [NUM_FU*DATA_W-1:0]     fu_value_in,
    output logic [NUM_FU-1:0]            fu_ready_out,
    output logic                         cdb_valid_out,
    output logic [ROB_IX_W-1:0]          cdb_rob_ix_out,
    output logic [DATA_W-1:0]            cdb_value_out,
`ifdef CDB_ARBITER_STATS_EN
    output logic [15:0]                  conflict_count_out,
`endif
    output logic [GW-1:0]                cdb_grant_fu_out
);
    logic [EW-1:0] mem [NUM_FU][FIFO_DEPTH];
    logic [PW-1:0] wp [NUM_FU];
    logic [PW-1:0] rp [NUM_FU];
    logic [CW-1:0] cnt [NUM_FU];
    logic [NUM_FU-1:0] ne, push, pop;
    logic [GW-1:0] rr, g;
    logic found;

    always_comb begin
        ne = '0;
        fu_ready_out = '0;
        push = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            ne[k] = cnt[k] != '0;
            fu_ready_out[k] = cnt[k] != CW'(FIFO_DEPTH);
            push[k] = fu_valid_in[k] && fu_ready_out[k];
        end
    end

    // First nonempty FIFO at or after rr, wrapping; only start-of-cycle occupancy counts.
    always_comb begin
        found = 1'b0;
        g = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (!found && ne[(int'(rr) + i) % NUM_FU]) begin
                found = 1'b1;
                g = GW'((int'(rr) + i) % NUM_FU);
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < NUM_FU; k++) pop[k] = found && g == GW'(k);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < NUM_FU; k++) begin
                cnt[k] <= '0;
                wp[k] <= '0;
                rp[k] <= '0;
            end
            rr <= '0;
            cdb_valid_out <= 1'b0;
            cdb_rob_ix_out <= '0;
            cdb_value_out <= '0;
            cdb_grant_fu_out <= '0;
        end else if (flush_in) begin
            for (int k = 0; k < NUM_FU; k++) begin
                cnt[k] <= '0;
                wp[k] <= '0;
                rp[k] <= '0;
            end
            rr <= '0;
            cdb_valid_out <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (push[k]) begin
                    mem[k][wp[k]] <= {fu_rob_ix_in[k*ROB_IX_W +: ROB_IX_W], fu_value_in[k*DATA_W +: DATA_W]};
                    wp[k] <= wp[k] + 1'b1;
                end
                if (pop[k]) rp[k] <= rp[k] + 1'b1;
                cnt[k] <= cnt[k] + CW'(push[k]) - CW'(pop[k]);
            end
            cdb_valid_out <= found;
            if (found) begin
                {cdb_rob_ix_out, cdb_value_out} <= mem[g][rp[g]];
                cdb_grant_fu_out <= g;
                rr <= (g == GW'(NUM_FU - 1)) ? '0 : g + 1'b1;
            end
        end
    end

`ifdef CDB_ARBITER_STATS_EN
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) conflict_count_out <= '0;
        else if ((ne & (ne - 1'b1)) != '0 && conflict_count_out != 16'hFFFF)
            conflict_count_out <= conflict_count_out + 1'b1;
    end
`endif
endmodule
